// File: rtl/sap_pkg.sv
// sap_pkg -- shared definitions for the SAP register bank.
//   op_e          : 3-bit operation code applied to the selected register
//   DEFAULT_WIDTH : default data width in bits
//   DEFAULT_NREGS : default register count (register 0 is the accumulator)
package sap_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'b000,
        OP_INC  = 3'b001,
        OP_DEC  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_ZERO = 3'b111
    } op_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_NREGS = 4;

endpackage

// File: rtl/sap_reg_op.sv
// sap_reg_op -- combinational operation unit for the register bank.
// Ports:
//   old_val : current value of the selected register
//   d       : bus write data (used by LOAD)
//   op      : operation code
//   result  : new register value
//   carry   : new carry/shift-out flag
module sap_reg_op
    import sap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] d,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Result and carry for every op; carry flags the wrap or the bit shifted out.
    always_comb begin
        result = {WIDTH{1'b0}};
        carry  = 1'b0;
        case (op)
            OP_LOAD: begin
                result = d;
                carry  = 1'b0;
            end
            OP_INC: begin
                result = old_val + ONE;
                carry  = &old_val;
            end
            OP_DEC: begin
                result = old_val - ONE;
                carry  = ~|old_val;
            end
            OP_SHL: begin
                result = {old_val[WIDTH-2:0], 1'b0};
                carry  = old_val[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, old_val[WIDTH-1:1]};
                carry  = old_val[0];
            end
            OP_ROL: begin
                result = {old_val[WIDTH-2:0], old_val[WIDTH-1]};
                carry  = old_val[WIDTH-1];
            end
            OP_ROR: begin
                result = {old_val[0], old_val[WIDTH-1:1]};
                carry  = old_val[0];
            end
            OP_ZERO: begin
                result = {WIDTH{1'b0}};
                carry  = 1'b0;
            end
            default: begin
                result = {WIDTH{1'b0}};
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sap_reg_bank.sv
// sap_reg_bank -- SAP-style register bank with accumulator and flags.
// Ports:
//   CLK      : rising-edge clock
//   CLR      : synchronous active-high reset (clears registers and flags)
//   D        : write data from the bus
//   L_       : active-low write enable
//   wsel     : register written / operated on
//   op       : operation code (sap_pkg::op_e), used only when L_=0
//   E        : bus output enable
//   rsel     : register driven onto the bus
//   OutToBus : regs[rsel] when E=1, else zero (wired-OR bus)
//   OutToALU : regs[0], always
//   C        : registered carry/shift-out flag
//   Z        : registered zero flag of the last written result
module sap_reg_bank
    import sap_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREGS = DEFAULT_NREGS
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic [WIDTH-1:0]         D,
    input  logic                     L_,
    input  logic [$clog2(NREGS)-1:0] wsel,
    input  logic [2:0]               op,
    input  logic                     E,
    input  logic [$clog2(NREGS)-1:0] rsel,
    output logic [WIDTH-1:0]         OutToBus,
    output logic [WIDTH-1:0]         OutToALU,
    output logic                     C,
    output logic                     Z
);

    logic [WIDTH-1:0] regs_r [NREGS];
    logic             c_r;
    logic             z_r;
    logic [WIDTH-1:0] old_val_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic [WIDTH-1:0] bus_s;
    op_e              op_s;

    assign old_val_s = regs_r[wsel];
    assign op_s      = op_e'(op);

    sap_reg_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .old_val (old_val_s),
        .d       (D),
        .op      (op_s),
        .result  (result_s),
        .carry   (carry_s)
    );

    // Register file and flags: CLR wins over any pending write.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            c_r <= 1'b0;
            z_r <= 1'b0;
        end else if (!L_) begin
            regs_r[wsel] <= result_s;
            c_r          <= carry_s;
            z_r          <= (result_s == {WIDTH{1'b0}});
        end
    end

    // Bus driver: zero when disabled so several sources can be OR-ed together.
    always_comb begin
        if (E) begin
            bus_s = regs_r[rsel];
        end else begin
            bus_s = {WIDTH{1'b0}};
        end
    end

    assign OutToBus = bus_s;
    assign OutToALU = regs_r[0];
    assign C        = c_r;
    assign Z        = z_r;

endmodule
